// File: rtl/cache_pkg.sv
// Shared D-cache types: store-buffer entry format and the port arbiter's state/op enums.
package cache_pkg;

  localparam int CACHE_VA_W = 32;

  // Store-buffer entry; enable marks the entry as valid.
  typedef struct packed {
    logic                  enable;
    logic [CACHE_VA_W-1:0] address;
    logic [CACHE_VA_W-1:0] data;
  } mem_data_t;

  typedef enum logic [1:0] {IDLE, REQ, RESP, REFILL} arb_state_e;
  typedef enum logic {OP_LD, OP_ST} arb_op_e;

endpackage

// File: rtl/dcache_arb_prio.sv
// Combinational grant decision for the D-cache port: forced store, load, then opportunistic store.
module dcache_arb_prio
  import cache_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             head_en,
  input  logic             full,
  input  logic             fence,
  input  logic             ld_req,
  input  logic             ld_alias,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant,
  output arb_op_e          op
);

  logic st_force;
  logic ld_ok;

  // A store must go first when the buffer is full, a fence drains, loads
  // have starved it, or the pending load aliases the head entry.
  assign st_force = head_en & (full | fence | ld_alias |
                               (starve_cnt == CNT_W'(STARVE_MAX)));
  assign ld_ok    = ld_req & ~fence & ~ld_alias;

  // Priority select of the next operation.
  always_comb begin
    grant = 1'b0;
    op    = OP_LD;
    if (st_force) begin
      grant = 1'b1;
      op    = OP_ST;
    end else if (ld_ok) begin
      grant = 1'b1;
      op    = OP_LD;
    end else if (head_en) begin
      grant = 1'b1;
      op    = OP_ST;
    end
  end

endmodule

// File: rtl/dcache_port_arb.sv
// D-cache request port owner: arbitrates MEM loads vs store-buffer commits and
// sequences each access through REQ -> RESP (-> REFILL -> REQ retry).
// Optional macro DCARB_PERF_EN adds load-hit / store-pop / refill-cycle counters.
module dcache_port_arb
  import cache_pkg::*;
#(
  parameter int VA_WIDTH   = CACHE_VA_W,
  parameter int STARVE_MAX = 4,
  parameter int PERF_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ld_req,
  input  logic [VA_WIDTH-1:0] i_ld_addr,
  output logic                o_ld_done,
  input  mem_data_t           i_stb_head,
  input  logic                i_stb_full,
  output logic                o_stb_pop,
  input  logic                i_fence,
  output logic                o_fence_done,
  output logic                o_cache_req,
  output logic                o_cache_we,
  output logic [VA_WIDTH-1:0] o_cache_addr,
  output logic [VA_WIDTH-1:0] o_cache_wdata,
  input  logic                i_cache_hit,
  input  logic                i_cache_busy
`ifdef DCARB_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] o_perf_ld,
  output logic [PERF_WIDTH-1:0] o_perf_st,
  output logic [PERF_WIDTH-1:0] o_perf_refill
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e          state;
  arb_op_e             op_q;
  arb_op_e             grant_op;
  logic                grant;
  logic                ld_alias;
  logic                resp_hit;
  logic [VA_WIDTH-1:0] addr_q;
  logic [VA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]    starve_cnt;

  // A load may not overtake an older store to the same address.
  assign ld_alias = i_stb_head.enable && (i_ld_addr == i_stb_head.address);

  dcache_arb_prio #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_prio (
    .head_en    (i_stb_head.enable),
    .full       (i_stb_full),
    .fence      (i_fence),
    .ld_req     (i_ld_req),
    .ld_alias   (ld_alias),
    .starve_cnt (starve_cnt),
    .grant      (grant),
    .op         (grant_op)
  );

  // Access sequencer; the operation is captured on leaving IDLE so retries reuse it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_LD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          op_q    <= grant_op;
          addr_q  <= (grant_op == OP_ST) ? i_stb_head.address : i_ld_addr;
          wdata_q <= (grant_op == OP_ST) ? i_stb_head.data : '0;
          state   <= REQ;
        end
        REQ:     state <= RESP;
        RESP:    state <= i_cache_hit ? IDLE : REFILL;
        REFILL:  if (!i_cache_busy) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

  // Count load grants that bypass a waiting store; saturate, clear on store grant or empty head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!i_stb_head.enable) begin
      starve_cnt <= '0;
    end else if (state == IDLE && grant) begin
      if (grant_op == OP_ST)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign resp_hit      = (state == RESP) && i_cache_hit;
  assign o_ld_done     = resp_hit && (op_q == OP_LD);
  assign o_stb_pop     = resp_hit && (op_q == OP_ST);
  assign o_cache_req   = (state == REQ);
  assign o_cache_we    = o_cache_req && (op_q == OP_ST);
  assign o_cache_addr  = o_cache_req ? addr_q : '0;
  assign o_cache_wdata = o_cache_we ? wdata_q : '0;
  assign o_fence_done  = !rst && i_fence && (state == IDLE) && !i_stb_head.enable;

`ifdef DCARB_PERF_EN
  // Free-running event counters, wrapping on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_perf_ld     <= '0;
      o_perf_st     <= '0;
      o_perf_refill <= '0;
    end else begin
      if (o_ld_done)        o_perf_ld     <= o_perf_ld + 1'b1;
      if (o_stb_pop)        o_perf_st     <= o_perf_st + 1'b1;
      if (state == REFILL)  o_perf_refill <= o_perf_refill + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_port_arb.sv
// Directed scoreboard bench for dcache_port_arb with a simple cache responder
// and a store-buffer queue model.
module tb_dcache_port_arb;
  import cache_pkg::*;

  typedef struct packed {
    logic [1:0]  kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ev_t;

  localparam logic [1:0] K_REQ  = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_POP  = 2'd2;

  logic        clk;
  logic        rst;
  logic        i_ld_req;
  logic [31:0] i_ld_addr;
  logic        o_ld_done;
  mem_data_t   i_stb_head;
  logic        i_stb_full;
  logic        o_stb_pop;
  logic        i_fence;
  logic        o_fence_done;
  logic        o_cache_req;
  logic        o_cache_we;
  logic [31:0] o_cache_addr;
  logic [31:0] o_cache_wdata;
  logic        i_cache_hit;
  logic        i_cache_busy;
`ifdef DCARB_PERF_EN
  logic [31:0] o_perf_ld;
  logic [31:0] o_perf_st;
  logic [31:0] o_perf_refill;
`endif

  ev_t       exp_q[$];
  mem_data_t stb_q[$];
  int checks, errors, cyc, n_req, n_done, n_pop, prev_req_cyc, last_req_cyc, busy_n;

  dcache_port_arb #(.VA_WIDTH(32), .STARVE_MAX(4), .PERF_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_ld_req      (i_ld_req),
    .i_ld_addr     (i_ld_addr),
    .o_ld_done     (o_ld_done),
    .i_stb_head    (i_stb_head),
    .i_stb_full    (i_stb_full),
    .o_stb_pop     (o_stb_pop),
    .i_fence       (i_fence),
    .o_fence_done  (o_fence_done),
    .o_cache_req   (o_cache_req),
    .o_cache_we    (o_cache_we),
    .o_cache_addr  (o_cache_addr),
    .o_cache_wdata (o_cache_wdata),
    .i_cache_hit   (i_cache_hit),
    .i_cache_busy  (i_cache_busy)
`ifdef DCARB_PERF_EN
    ,
    .o_perf_ld     (o_perf_ld),
    .o_perf_st     (o_perf_st),
    .o_perf_refill (o_perf_refill)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
    ev_t e;
    e = {k, we, a, d};
    exp_q.push_back(e);
  endtask

  task automatic set_head();
    i_stb_head = (stb_q.size() != 0) ? stb_q[0] : '0;
    i_stb_full = (stb_q.size() >= 4);
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d);
    mem_data_t m;
    m = {1'b1, a, d};
    stb_q.push_back(m);
    set_head();
  endtask

  task automatic expect_ev(input string tag, input ev_t got);
    ev_t e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    chk(tag, 72'(got), 72'(e));
  endtask

  // Observes the cache port and completions once per cycle on the falling edge.
  task automatic monitor_loop();
    ev_t g;
    forever begin
      @(negedge clk);
      cyc++;
      if (o_cache_req) begin
        n_req++;
        prev_req_cyc = last_req_cyc;
        last_req_cyc = cyc;
        g = {K_REQ, o_cache_we, o_cache_addr, o_cache_wdata};
        expect_ev("ev_req", g);
      end
      if (o_ld_done) begin
        n_done++;
        g = {K_DONE, 1'b0, 32'h0, 32'h0};
        expect_ev("ev_done", g);
      end
      if (o_stb_pop) begin
        n_pop++;
        g = {K_POP, 1'b0, 32'h0, 32'h0};
        expect_ev("ev_pop", g);
        if (stb_q.size() != 0) void'(stb_q.pop_front());
        set_head();
      end
    end
  endtask

  // Cache model: answers each request the next cycle with hit, or with busy for busy_n cycles.
  task automatic cache_loop();
    forever begin
      @(posedge clk); #1;
      if (o_cache_req) begin
        @(posedge clk); #1;
        if (busy_n == 0) begin
          i_cache_hit = 1'b1;
          @(posedge clk); #1;
          i_cache_hit = 1'b0;
        end else begin
          i_cache_busy = 1'b1;
          repeat (busy_n) @(posedge clk);
          #1;
          i_cache_busy = 1'b0;
          busy_n = 0;
        end
      end
    end
  endtask

  task automatic wait_cnt(input string tag, input int kind, input int target);
    int k;
    int cur;
    for (k = 0; k < 300; k++) begin
      cur = (kind == 0) ? n_req : (kind == 1) ? n_done : n_pop;
      if (cur >= target) break;
      @(negedge clk); #1;
    end
    chk(tag, 72'(k < 300), 72'(1));
  endtask

  initial begin
    int d0;
    int p0;
    checks = 0; errors = 0; cyc = 0; n_req = 0; n_done = 0; n_pop = 0;
    prev_req_cyc = 0; last_req_cyc = 0; busy_n = 0;
    rst = 1'b1; i_ld_req = 1'b0; i_ld_addr = '0; i_fence = 1'b1;
    i_cache_hit = 1'b0; i_cache_busy = 1'b0;
    set_head();
    fork
      monitor_loop();
      cache_loop();
    join_none

    // Reset: every output low, even with a fence requested.
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 72'({o_cache_req, o_cache_we, o_cache_addr, o_cache_wdata,
                           o_ld_done, o_stb_pop, o_fence_done}), 72'(0));
    i_fence = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 1: single load hit, req at cycle 1, done at cycle 2.
    @(negedge clk);
    i_ld_addr = 32'h40; i_ld_req = 1'b1;
    push_ev(K_REQ, 1'b0, 32'h40, 32'h0);
    push_ev(K_DONE, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #2;
    chk("t1_req_c1", 72'({o_cache_req, o_cache_we, o_cache_addr}), 72'({1'b1, 1'b0, 32'h40}));
    @(posedge clk); #2;
    chk("t1_done_c2", 72'({o_ld_done, o_stb_pop}), 72'(2'b10));
    i_ld_req = 1'b0;
    wait_cnt("t1_wait", 1, 1);

    // 2: store starved by 4 loads, then forced.
    @(negedge clk);
    d0 = n_done; p0 = n_pop;
    push_store(32'h80, 32'hDEAD);
    i_ld_addr = 32'h44; i_ld_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_ev(K_REQ, 1'b0, 32'h44, 32'h0);
      push_ev(K_DONE, 1'b0, 32'h0, 32'h0);
    end
    push_ev(K_REQ, 1'b1, 32'h80, 32'hDEAD);
    push_ev(K_POP, 1'b0, 32'h0, 32'h0);
    wait_cnt("t2_wait", 2, p0 + 1);
    i_ld_req = 1'b0;
    chk("t2_loads_before_st", 72'(n_done - d0), 72'(4));

    // 3: store hits a refill for 3 cycles and retries with the same addr/data.
    @(negedge clk);
    p0 = n_pop;
    busy_n = 3;
    push_store(32'h200, 32'hBEEF);
    push_ev(K_REQ, 1'b1, 32'h200, 32'hBEEF);
    push_ev(K_REQ, 1'b1, 32'h200, 32'hBEEF);
    push_ev(K_POP, 1'b0, 32'h0, 32'h0);
    wait_cnt("t3_wait", 2, p0 + 1);
    chk("t3_retry_gap", 72'(last_req_cyc - prev_req_cyc), 72'(5));

    // 4: load aliasing the head store waits for the store.
    @(negedge clk);
    d0 = n_done;
    push_store(32'h100, 32'h1234);
    i_ld_addr = 32'h100; i_ld_req = 1'b1;
    push_ev(K_REQ, 1'b1, 32'h100, 32'h1234);
    push_ev(K_POP, 1'b0, 32'h0, 32'h0);
    push_ev(K_REQ, 1'b0, 32'h100, 32'h0);
    push_ev(K_DONE, 1'b0, 32'h0, 32'h0);
    wait_cnt("t4_wait", 1, d0 + 1);
    i_ld_req = 1'b0;

    // 5: fence drains two stores while a load is blocked.
    @(negedge clk);
    p0 = n_pop;
    i_fence = 1'b1; i_ld_addr = 32'h500; i_ld_req = 1'b1;
    push_store(32'h300, 32'h1);
    push_store(32'h304, 32'h2);
    chk("t5_fence_busy", 72'(o_fence_done), 72'(0));
    push_ev(K_REQ, 1'b1, 32'h300, 32'h1);
    push_ev(K_POP, 1'b0, 32'h0, 32'h0);
    push_ev(K_REQ, 1'b1, 32'h304, 32'h2);
    push_ev(K_POP, 1'b0, 32'h0, 32'h0);
    wait_cnt("t5_wait", 2, p0 + 2);
    @(posedge clk); #2;
    chk("t5_fence_done", 72'(o_fence_done), 72'(1));
    repeat (3) @(negedge clk);
    #1;
    chk("t5_fence_hold", 72'({o_fence_done, o_cache_req}), 72'(2'b10));
    i_fence = 1'b0; i_ld_req = 1'b0;

    // 6: reset during RESP of a store abandons it; it re-issues afterwards.
    @(negedge clk);
    p0 = n_pop;
    push_store(32'h400, 32'h5555);
    push_ev(K_REQ, 1'b1, 32'h400, 32'h5555);
    wait_cnt("t6_wait_req", 0, n_req + 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", 72'({o_cache_req, o_cache_we, o_cache_addr, o_cache_wdata,
                            o_ld_done, o_stb_pop, o_fence_done}), 72'(0));
    repeat (2) @(negedge clk);
    chk("t6_no_pop", 72'({n_pop - p0, stb_q.size()}), 72'({32'd0, 32'd1}));
    rst = 1'b0;
    push_ev(K_REQ, 1'b1, 32'h400, 32'h5555);
    push_ev(K_POP, 1'b0, 32'h0, 32'h0);
    wait_cnt("t6_wait_pop", 2, p0 + 1);
    chk("t6_stb_empty", 72'(stb_q.size()), 72'(0));

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 72'(exp_q.size()), 72'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
